// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback requesters (A: ALU, B: LSU) and
// the register file write port. The requesters sit on the master side; the
// arbiter sits on the slave side.
//
// Handshake: a request transfers in any cycle where its VALID and READY are
// both 1. Once VALID rises, RD and DATA stay stable until the transfer.
// READY is combinational from both VALIDs and the arbiter state, and never
// depends on the requester's own VALID.
interface regfile_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  A_VALID;
    logic [ADDR_WIDTH-1:0] A_RD;
    logic [DATA_WIDTH-1:0] A_DATA;
    logic                  A_READY;

    logic                  B_VALID;
    logic [ADDR_WIDTH-1:0] B_RD;
    logic [DATA_WIDTH-1:0] B_DATA;
    logic                  B_READY;

    logic                  WEN;
    logic [ADDR_WIDTH-1:0] RD_SEL;
    logic [DATA_WIDTH-1:0] WB_DATA;
    logic                  GRANT_B;

    modport master (
        output A_VALID, A_RD, A_DATA,
        input  A_READY,
        output B_VALID, B_RD, B_DATA,
        input  B_READY,
        input  WEN, RD_SEL, WB_DATA, GRANT_B
    );

    modport slave (
        input  A_VALID, A_RD, A_DATA,
        output A_READY,
        input  B_VALID, B_RD, B_DATA,
        output B_READY,
        output WEN, RD_SEL, WB_DATA, GRANT_B
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter. A has fixed priority; a saturating
// starvation counter promotes B to priority after STARVE_LIMIT refused
// cycles (legal range 1..15). The winning write is registered onto
// WEN/RD_SEL/WB_DATA one cycle after acceptance. Writes to index 0 are
// consumed but never reach the port, and idle outputs are held at zero so
// the register file's WB_DATA bypass only ever matches index 0.
module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                    CLK,
    input  logic                    RESET,
    regfile_wb_arbiter_if.slave     bus,
    output logic                    dbg_b_prio,
    output logic [3:0]              dbg_starve_cnt
);
    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_B_PRIO = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t                state_q, state_d;
    logic [3:0]            starve_cnt_q, starve_cnt_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] rd_sel_q, rd_sel_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                  grant_b_q, grant_b_d;

    logic                  a_ready;
    logic                  b_ready;
    logic                  a_xfer;
    logic                  b_xfer;

    // READY generation: the state decides who wins when both are valid.
    always_comb begin
        a_ready = 1'b1;
        b_ready = 1'b1;
        if (state_q == ST_NORMAL) begin
            b_ready = !bus.A_VALID;
        end else begin
            a_ready = !bus.B_VALID;
        end
        a_xfer = bus.A_VALID && a_ready;
        b_xfer = bus.B_VALID && b_ready;
    end

    // Starvation counter and NORMAL/B_PRIO next state.
    always_comb begin
        starve_cnt_d = 4'd0;
        state_d      = state_q;
        if (bus.B_VALID && !b_ready) begin
            starve_cnt_d = (starve_cnt_q == 4'hF) ? starve_cnt_q : starve_cnt_q + 4'd1;
        end
        case (state_q)
            ST_NORMAL: begin
                // Compare against the count being written this edge.
                if (bus.B_VALID && !b_ready && (starve_cnt_d >= LIMIT)) begin
                    state_d = ST_B_PRIO;
                end
            end
            ST_B_PRIO: begin
                // Dropping B_VALID here is illegal but must not wedge us.
                if (b_xfer || !bus.B_VALID) begin
                    state_d = ST_NORMAL;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    // Write-port next value: the single winner, or all zeros.
    always_comb begin
        wen_d     = 1'b0;
        rd_sel_d  = '0;
        wb_data_d = '0;
        grant_b_d = 1'b0;
        if (a_xfer) begin
            if (bus.A_RD != '0) begin
                wen_d     = 1'b1;
                rd_sel_d  = bus.A_RD;
                wb_data_d = bus.A_DATA;
            end
        end else if (b_xfer) begin
            if (bus.B_RD != '0) begin
                wen_d     = 1'b1;
                rd_sel_d  = bus.B_RD;
                wb_data_d = bus.B_DATA;
                grant_b_d = 1'b1;
            end
        end
    end

    // State, counter and output registers; reset wins over any transfer.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_NORMAL;
            starve_cnt_q <= 4'd0;
            wen_q        <= 1'b0;
            rd_sel_q     <= '0;
            wb_data_q    <= '0;
            grant_b_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            wen_q        <= wen_d;
            rd_sel_q     <= rd_sel_d;
            wb_data_q    <= wb_data_d;
            grant_b_q    <= grant_b_d;
        end
    end

    assign bus.A_READY    = a_ready;
    assign bus.B_READY    = b_ready;
    assign bus.WEN        = wen_q;
    assign bus.RD_SEL     = rd_sel_q;
    assign bus.WB_DATA    = wb_data_q;
    assign bus.GRANT_B    = grant_b_q;
    assign dbg_b_prio     = (state_q == ST_B_PRIO);
    assign dbg_starve_cnt = starve_cnt_q;
endmodule
